// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file and its busy-bit scoreboard.
package regfile_pkg;
  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);
  localparam int ZERO_REG      = 0;

  typedef logic [AW_DEFAULT-1:0] reg_addr_t;
endpackage

// File: rtl/busy_table.sv
// Busy-bit scoreboard: one pending-write flag per register, with next-state priority
// reset > flush > set > clear. Entry 0 never becomes busy.
module busy_table
  import regfile_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NWRITE = 2,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 set_vld,
  input  logic [AW-1:0]        set_addr,
  input  logic [NWRITE-1:0]    we,
  input  logic [NWRITE*AW-1:0] waddr,
  output logic [NREGS-1:0]     busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Clear first, then set, so a new producer supersedes a retiring one.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWRITE; k++) begin
      if (we[k]) busy_d[waddr[k*AW +: AW]] = 1'b0;
    end
    if (set_vld) busy_d[set_addr] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with same-cycle write bypass, hardwired x0,
// and a busy-bit scoreboard reporting RAW (rd_ready) and WAW (issue_ready) hazards.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_ready,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   waddr,
  input  logic [NWRITE*XLEN-1:0] wdata,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_rd,
  output logic                   issue_ready,
  input  logic                   flush
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [AW-1:0]     wa [NWRITE];
  logic [XLEN-1:0]   wd [NWRITE];
  logic [NWRITE-1:0] wr_en;
  logic [NWRITE-1:0] issue_hit;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic [XLEN-1:0]   mem_d [NREGS];
  logic [NREGS-1:0]  busy;
  logic              issue_acc;

  for (genvar k = 0; k < NWRITE; k++) begin : g_wport
    assign wa[k]        = waddr[k*AW +: AW];
    assign wd[k]        = wdata[k*XLEN +: XLEN];
    assign wr_en[k]     = we[k] && (wa[k] != ZERO_ADDR);
    assign issue_hit[k] = we[k] && (wa[k] == issue_rd);
  end

  // Higher-numbered ports are applied later, so they win on address collisions.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NWRITE; k++) begin
      if (wr_en[k]) mem_d[wa[k]] = wd[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= mem_d[r];
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rport
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            hit;

    assign ra = rd_addr[i*AW +: AW];

    always_comb begin
      rdat = mem_q[ra];
      hit  = 1'b0;
      for (int k = 0; k < NWRITE; k++) begin
        if (we[k] && (wa[k] == ra)) begin
          hit  = 1'b1;
          rdat = wd[k];
        end
      end
      if (reset || (ra == ZERO_ADDR)) rdat = '0;
    end

    assign rd_data[i*XLEN +: XLEN] = rdat;
    assign rd_ready[i] = reset || (ra == ZERO_ADDR) || !busy[ra] || hit;
  end

  // A writeback to issue_rd in this cycle lets the new producer take over the entry.
  assign issue_ready = reset || (issue_rd == ZERO_ADDR) || !busy[issue_rd] || (|issue_hit);
  assign issue_acc   = !reset && issue_valid && issue_ready && !flush && (issue_rd != ZERO_ADDR);

  busy_table #(
    .NREGS  (NREGS),
    .NWRITE (NWRITE),
    .AW     (AW)
  ) u_busy (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .set_vld  (issue_acc),
    .set_addr (issue_rd),
    .we       (we),
    .waddr    (waddr),
    .busy     (busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb against a register/busy-array model.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int XL = 32;
  localparam int NR = 32;
  localparam int A  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*A-1:0]  rd_addr;
  logic [2*XL-1:0] rd_data;
  logic [1:0]      rd_ready;
  logic [1:0]      we;
  logic [2*A-1:0]  waddr;
  logic [2*XL-1:0] wdata;
  logic            issue_valid;
  reg_addr_t       issue_rd;
  logic            issue_ready;
  logic            flush;

  int total = 0;
  int bad   = 0;

  logic [XL-1:0] mdl_mem  [NR];
  bit            mdl_busy [NR];
  logic [XL-1:0] nxt_mem  [NR];
  bit            nxt_busy [NR];

  regfile_sb dut (
    .clk(clk), .reset(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int r = 0; r < NR; r++) begin
      mdl_mem[r] = '0; mdl_busy[r] = 0; nxt_mem[r] = '0; nxt_busy[r] = 0;
    end
  end

  always @(posedge rst) begin
    for (int r = 0; r < NR; r++) begin
      mdl_mem[r] = '0; mdl_busy[r] = 0;
    end
  end

  always @(posedge clk) begin
    for (int r = 0; r < NR; r++) begin
      mdl_mem[r]  = rst ? '0 : nxt_mem[r];
      mdl_busy[r] = rst ? 0 : nxt_busy[r];
    end
  end

  // Expected outputs from the model and current inputs; also the state after the next edge.
  always @(negedge clk) begin : compare
    int a, wa0, wa1, ir;
    logic [XL-1:0] ed;
    bit er, eir, hit, acc;
    wa0 = int'(waddr[0 +: A]);
    wa1 = int'(waddr[A +: A]);
    ir  = int'(issue_rd);
    for (int i = 0; i < 2; i++) begin
      a = int'(rd_addr[i*A +: A]);
      hit = (we[0] && wa0 == a) || (we[1] && wa1 == a);
      if (rst || a == 0) begin
        ed = '0; er = 1;
      end else begin
        if (we[1] && wa1 == a)      ed = wdata[XL +: XL];
        else if (we[0] && wa0 == a) ed = wdata[0 +: XL];
        else                        ed = mdl_mem[a];
        er = !mdl_busy[a] || hit;
      end
      chk($sformatf("rd_data%0d", i), 64'(rd_data[i*XL +: XL]), 64'(ed));
      chk($sformatf("rd_ready%0d", i), 64'(rd_ready[i]), 64'(er));
    end
    eir = rst || ir == 0 || !mdl_busy[ir] || (we[0] && wa0 == ir) || (we[1] && wa1 == ir);
    chk("issue_ready", 64'(issue_ready), 64'(eir));
    acc = !rst && issue_valid && eir && !flush && ir != 0;
    for (int r = 0; r < NR; r++) begin
      nxt_mem[r] = mdl_mem[r];
      if (flush)                                              nxt_busy[r] = 0;
      else if (acc && r == ir)                                nxt_busy[r] = 1;
      else if ((we[0] && wa0 == r) || (we[1] && wa1 == r))    nxt_busy[r] = 0;
      else                                                    nxt_busy[r] = mdl_busy[r];
    end
    if (we[0] && wa0 != 0) nxt_mem[wa0] = wdata[0 +: XL];
    if (we[1] && wa1 != 0) nxt_mem[wa1] = wdata[XL +: XL];
  end

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; issue_valid = 0; issue_rd = '0; flush = 0; rd_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int p, input int addr, input logic [XL-1:0] d);
    we[p] = 1'b1;
    waddr[p*A +: A] = A'(addr);
    wdata[p*XL +: XL] = d;
  endtask

  task automatic rd(input int p, input int addr);
    rd_addr[p*A +: A] = A'(addr);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_rd_ready", 64'(rd_ready), 64'd3);
    chk("reset_issue_ready", 64'(issue_ready), 64'd1);
    @(posedge clk); #1 rst = 1'b0;

    step(); wr(0, 5, 32'hDEADBEEF); rd(0, 5); rd(1, 0);
    #2 chk("bypass_x5", 64'(rd_data[0 +: XL]), 64'hDEADBEEF);
    chk("x0_reads_zero", 64'(rd_data[XL +: XL]), 64'd0);
    step(); rd(0, 5);
    #2 chk("array_x5", 64'(rd_data[0 +: XL]), 64'hDEADBEEF);
    chk("model_x5", 64'(mdl_mem[5]), 64'hDEADBEEF);

    step(); wr(0, 7, 32'h1111); wr(1, 7, 32'h2222); rd(0, 7);
    #2 chk("bypass_x7_port1_wins", 64'(rd_data[0 +: XL]), 64'h2222);
    step(); rd(0, 7);
    #2 chk("array_x7_port1_wins", 64'(rd_data[0 +: XL]), 64'h2222);

    step(); issue_valid = 1; issue_rd = 3;
    step(); rd(0, 3); issue_rd = 3;
    #2 chk("raw_x3_not_ready", 64'(rd_ready[0]), 64'd0);
    chk("waw_x3_stall", 64'(issue_ready), 64'd0);
    step(); wr(0, 3, 32'h42); rd(0, 3); issue_rd = 3;
    #2 chk("wb_x3_ready", 64'(rd_ready[0]), 64'd1);
    chk("wb_x3_data", 64'(rd_data[0 +: XL]), 64'h42);
    chk("wb_x3_issue_ready", 64'(issue_ready), 64'd1);
    step(); rd(0, 3);
    #2 chk("x3_cleared", 64'(rd_ready[0]), 64'd1);

    step(); issue_valid = 1; issue_rd = 9; wr(0, 9, 32'h99);
    step(); rd(0, 9); issue_rd = 9;
    #2 chk("set_wins_x9", 64'(rd_ready[0]), 64'd0);
    chk("model_busy_x9", 64'(mdl_busy[9]), 64'd1);
    step(); wr(0, 9, 32'h9A);

    step(); issue_valid = 1; issue_rd = 4; flush = 1;
    step(); rd(0, 4); issue_rd = 4;
    #2 chk("flush_drops_issue", 64'(rd_ready[0]), 64'd1);
    chk("model_busy_x4", 64'(mdl_busy[4]), 64'd0);
    step(); issue_valid = 1; issue_rd = 2; wr(0, 2, 32'hAA);
    step(); issue_valid = 1; issue_rd = 6; wr(1, 6, 32'hBB);
    step(); rd(0, 2); rd(1, 6);
    #2 chk("busy_x2_x6", 64'(rd_ready), 64'd0);
    step(); flush = 1;
    step(); rd(0, 2); rd(1, 6);
    #2 chk("flush_ready", 64'(rd_ready), 64'd3);
    chk("flush_keeps_x2", 64'(rd_data[0 +: XL]), 64'hAA);
    chk("flush_keeps_x6", 64'(rd_data[XL +: XL]), 64'hBB);

    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 99) == 0);
      we = 2'($urandom);
      waddr = {A'($urandom_range(0, 7)), A'($urandom_range(0, 7))};
      wdata = {$urandom, $urandom};
      rd_addr = {A'($urandom_range(0, 7)), A'($urandom_range(0, 7))};
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_rd = A'($urandom_range(0, 7));
      flush = ($urandom_range(0, 19) == 0);
    end
    step(); rst = 1'b0;

    step(); wr(0, 10, 32'h55); issue_valid = 1; issue_rd = 11;
    step(); rd(0, 10); rd(1, 11); issue_rd = 11; wr(1, 12, 32'h77);
    #1 rst = 1'b1;
    #1 chk("async_rst_rd_data", 64'(rd_data), 64'd0);
    chk("async_rst_rd_ready", 64'(rd_ready), 64'd3);
    chk("async_rst_issue_ready", 64'(issue_ready), 64'd1);
    step(); rst = 1'b0; wr(0, 0, 32'hFFFFFFFF); rd(0, 0); rd(1, 10);
    #2 chk("x0_write_dropped", 64'(rd_data[0 +: XL]), 64'd0);
    chk("x0_ready", 64'(rd_ready[0]), 64'd1);
    chk("x10_cleared", 64'(rd_data[XL +: XL]), 64'd0);
    step(); rd(0, 0);
    #2 chk("x0_after_write", 64'(rd_data[0 +: XL]), 64'd0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
